uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver with configurable character format, per-character error flags, break detection and a small receive FIFO. It replaces the fixed 8N1 receiver between the serial input pin and the command decoder. A consumer can now absorb bursts without losing bytes and can reject corrupted characters.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit (i_Clock frequency / baud); legal range 4..65535.
- DATA_BITS, 8: data bits per character; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits checked; 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of 2, 2..64.

- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  reset; asynchronous assert, active-low.
- i_RX_Serial  in  1  asynchronous serial line; idles high.
- i_Rd_En  in  1  pops the FIFO head when o_RX_Valid = 1.
- o_RX_Valid  out  1  FIFO not empty; head presented on o_RX_Data and the flags.
- o_RX_Data  out  DATA_BITS  head character, LSB received first.
- o_Parity_Err  out  1  head character failed the parity check (0 when PARITY = 0).
- o_Frame_Err  out  1  head character had at least one low stop-bit sample.
- o_Overrun  out  1  one-cycle pulse: a completed character was dropped because the FIFO was full.
- o_Break  out  1  one-cycle pulse: break detected; nothing is pushed.

## Operation
- Input path: 2-flop synchroniser on i_RX_Serial, both flops reset to 1. The FSM sees only the synchronised value.
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index: width $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: counter = 0, index = 0. A synchronised low moves to START.
  - START: counts to (CLKS_PER_BIT-1)/2, then samples.
    - Sample low: counter cleared, go to DATA.
    - Sample high: glitch; go to IDLE with no push and no flags.
  - DATA: samples every CLKS_PER_BIT cycles (counter reaches CLKS_PER_BIT-1). Shifts LSB-first into the shift register. After DATA_BITS samples, goes to PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. Error if XOR(data, parity bit) = 0 for odd parity, or = 1 for even parity.
  - STOP: STOP_BITS samples, one bit period apart. Any low sample sets the frame error.
- Completion (cycle after the final stop sample):
  - Break: all data bits, the parity bit (if present) and every stop sample are 0. Pulse o_Break, do not push, go to IDLE. IDLE then waits for the line to return high before a new start bit is accepted.
  - Otherwise: push {parity_err, frame_err, data}. If the FIFO is full and i_Rd_En is not active the same cycle, drop the character and pulse o_Overrun.
  - Always go to IDLE.
- FIFO: first-word-fall-through.
  - Pop on i_Rd_En & o_RX_Valid. i_Rd_En while empty is ignored.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: the push is accepted; o_RX_Valid is high the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.
- Reset, at any time including mid-frame:
  - FSM to IDLE, FIFO empty, counters cleared, synchroniser set to 1.
  - All outputs 0.
  - A partial frame in progress is discarded.

## Timing
- Start detection: 2 cycles of synchroniser latency from the line edge, then 1 cycle to enter START.
- First data sample: (CLKS_PER_BIT-1)/2 + CLKS_PER_BIT cycles after START entry. Each subsequent sample is CLKS_PER_BIT cycles later.
- Push: the cycle after the last stop sample. o_RX_Valid rises on the following edge.
- End-to-end latency: about 2 cycles after the stop-bit midpoint plus synchroniser delay (~4 cycles).
- o_Overrun and o_Break: high for exactly one cycle, on the push cycle.
- o_RX_Data and the flags: registered. Stable while o_RX_Valid = 1 and no pop occurs.
- Back-to-back characters: supported with zero idle time, because IDLE is re-entered half a bit before the stop bit ends.

## Test plan
- 8N1 with CLKS_PER_BIT = 16: send 0x55, then 0xA3 back-to-back -> two FIFO entries, 0x55 then 0xA3, both flags 0, no pulses.
- PARITY = 2 (even), 8 data bits: send 0x07 with parity bit 1 -> o_Parity_Err = 0. Send 0x07 with parity bit 0 -> o_Parity_Err = 1, data 0x07.
- Send 0x3C with the stop bit low (line high afterwards) -> entry 0x3C, o_Frame_Err = 1.
- Hold the line low for 2 frame times -> exactly one o_Break pulse, FIFO stays empty. Then 0x41 -> 0x41 received cleanly.
- FIFO_DEPTH = 4, no reads: send 0x01..0x05 -> one o_Overrun pulse on the 5th character. Pops return 0x01..0x04, then o_RX_Valid = 0.
- 3-cycle low glitch at CLKS_PER_BIT = 16 -> no push and no flags. Separately, assert i_Rst_L low mid-DATA, then send 0x99 -> outputs 0 during reset, only 0x99 received.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Receive-side consumer handshake for uart_rx_cfg: FIFO head, per-character
// flags, and the pop strobe.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rd_En;
    logic                 o_RX_Valid;
    logic [DATA_BITS-1:0] o_RX_Data;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Overrun;
    logic                 o_Break;

    modport master (
        output i_Rd_En,
        input  o_RX_Valid, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Overrun, o_Break
    );

    modport slave (
        input  i_Rd_En,
        output o_RX_Valid, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Overrun, o_Break
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N data bits, optional parity, 1/2 stop bits,
// break detection and a first-word-fall-through receive FIFO.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_RX_Serial,
    uart_rx_cfg_if.slave  rx_if
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(DATA_BITS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CNW = AW + 1;
    localparam int EW  = DATA_BITS + 2;
    localparam logic [CW-1:0]  HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  DLAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]  SLAST = IW'(STOP_BITS - 1);
    localparam logic [CNW-1:0] FULL  = CNW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state;
    logic                 rx_meta, rx_sync;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop_lo, stop_hi;
    logic                 brk_wait, done, done_fe, done_brk;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    // done is a one-cycle completion strobe; the FIFO side acts on it while
    // the FSM is already back in IDLE hunting for the next start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_lo  <= 1'b0;
            stop_hi  <= 1'b0;
            brk_wait <= 1'b0;
            done     <= 1'b0;
            done_fe  <= 1'b0;
            done_brk <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (brk_wait) begin
                        if (rx_sync) brk_wait <= 1'b0;
                    end else if (!rx_sync) begin
                        state   <= S_START;
                        par_bit <= 1'b0;
                        stop_lo <= 1'b0;
                        stop_hi <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rx_sync ? S_IDLE : S_DATA;
                    end else cnt <= cnt + CW'(1);
                end
                S_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                        if (idx == DLAST) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else idx <= idx + IW'(1);
                    end else cnt <= cnt + CW'(1);
                end
                S_PAR: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_sync;
                        state   <= S_STOP;
                    end else cnt <= cnt + CW'(1);
                end
                S_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (idx == SLAST) begin
                            idx      <= '0;
                            done     <= 1'b1;
                            done_fe  <= stop_lo | ~rx_sync;
                            done_brk <= ~|shreg & ~par_bit & ~stop_hi & ~rx_sync;
                            brk_wait <= ~|shreg & ~par_bit & ~stop_hi & ~rx_sync;
                            state    <= S_IDLE;
                        end else begin
                            idx     <= idx + IW'(1);
                            stop_lo <= stop_lo | ~rx_sync;
                            stop_hi <= stop_hi | rx_sync;
                        end
                    end else cnt <= cnt + CW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic calc_pe;
    always_comb begin
        calc_pe = 1'b0;
        if (PARITY == 1)      calc_pe = ~(^shreg ^ par_bit);
        else if (PARITY == 2) calc_pe = ^shreg ^ par_bit;
    end

    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CNW-1:0] count;
    logic           push_req, pop, full, push, ovr_q, brk_q;

    assign push_req = done & ~done_brk;
    assign full     = (count == FULL);
    assign pop      = rx_if.i_Rd_En & (count != '0);
    assign push     = push_req & (~full | pop);

    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= {calc_pe, done_fe, shreg};
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CNW'(1);
            else if (pop && !push) count <= count - CNW'(1);
            ovr_q <= push_req & full & ~pop;
            brk_q <= done & done_brk;
        end
    end

    // Head is gated by valid so stale storage never shows after reset or drain.
    logic [EW-1:0] head;
    assign head               = mem[rd_ptr];
    assign rx_if.o_RX_Valid   = (count != '0);
    assign rx_if.o_RX_Data    = rx_if.o_RX_Valid ? head[DATA_BITS-1:0] : '0;
    assign rx_if.o_Frame_Err  = rx_if.o_RX_Valid & head[DATA_BITS];
    assign rx_if.o_Parity_Err = rx_if.o_RX_Valid & head[DATA_BITS+1];
    assign rx_if.o_Overrun    = ovr_q;
    assign rx_if.o_Break      = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized bench for uart_rx_cfg (8E1, 16 clocks/bit, 4-deep FIFO) checked
// against a queue-based model of received characters and pulse counts.
module tb_uart_rx_cfg;
    localparam int CPB = 16, DB = 8, PAR = 2, SB = 1, DEPTH = 4;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(DB)) rx_if ();
    uart_rx_cfg #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx), .rx_if(rx_if)
    );

    int n_chk = 0, n_pass = 0;
    int ovr_seen = 0, brk_seen = 0, exp_ovr = 0, exp_brk = 0;
    logic [9:0] exp_q [$];   // {parity_err, frame_err, data}

    always @(negedge clk) begin
        if (rx_if.o_Overrun) ovr_seen++;
        if (rx_if.o_Break)   brk_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame on the wire, then the model's view of what the receiver must do with it.
    task automatic send(input logic [7:0] d, input bit bad_par, input bit stop_low);
        logic p;
        p = (^d) ^ bad_par;
        bit_out(1'b0);
        for (int i = 0; i < DB; i++) bit_out(d[i]);
        bit_out(p);
        bit_out(~stop_low);
        rx = 1'b1;
        if (d == 8'h00 && !p && stop_low) exp_brk++;
        else if (exp_q.size() < DEPTH) exp_q.push_back({^{d, p}, stop_low, d});
        else exp_ovr++;
    endtask

    task automatic pulses(input string tag);
        chk({tag, ".ovr"}, ovr_seen, exp_ovr);
        chk({tag, ".brk"}, brk_seen, exp_brk);
    endtask

    task automatic drain(input string tag);
        logic [9:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".vld"},  rx_if.o_RX_Valid, 1);
            chk({tag, ".data"}, rx_if.o_RX_Data, e[7:0]);
            chk({tag, ".fe"},   rx_if.o_Frame_Err, e[8]);
            chk({tag, ".pe"},   rx_if.o_Parity_Err, e[9]);
            rx_if.i_Rd_En = 1'b1;
            @(negedge clk);
            rx_if.i_Rd_En = 1'b0;
        end
        chk({tag, ".empty"}, rx_if.o_RX_Valid, 0);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, ".vld"},  rx_if.o_RX_Valid, 0);
        chk({tag, ".data"}, rx_if.o_RX_Data, 0);
        chk({tag, ".flags"}, {rx_if.o_Parity_Err, rx_if.o_Frame_Err, rx_if.o_Overrun, rx_if.o_Break}, 0);
    endtask

    initial begin
        logic [7:0] d;
        bit bp, sl;
        int n;
        rx_if.i_Rd_En = 1'b0;
        repeat (3) @(negedge clk);
        outs_zero("rst");
        rst_n = 1'b1;
        idle(5);

        send(8'h55, 0, 0);
        send(8'hA3, 0, 0);
        idle(20);
        pulses("b2b");
        drain("b2b");

        send(8'h07, 0, 0);
        send(8'h07, 1, 0);
        idle(20);
        drain("par");

        send(8'h3C, 0, 1);
        idle(2 * CPB);
        drain("frm");

        rx = 1'b0;
        repeat (2 * 11 * CPB) @(negedge clk);
        exp_brk++;
        idle(2 * CPB);
        pulses("brk");
        chk("brk.empty", rx_if.o_RX_Valid, 0);
        send(8'h41, 0, 0);
        idle(20);
        drain("brk_after");

        for (int i = 1; i <= 5; i++) send(8'(i), 0, 0);
        idle(20);
        pulses("ovr");
        drain("ovr");

        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * CPB);
        chk("glitch.vld", rx_if.o_RX_Valid, 0);
        pulses("glitch");

        rx_if.i_Rd_En = 1'b1;
        repeat (3) @(negedge clk);
        rx_if.i_Rd_En = 1'b0;
        send(8'h5A, 0, 0);
        idle(20);
        drain("rd_empty");

        send(8'h12, 0, 0);
        idle(10);
        chk("mid.pre_vld", rx_if.o_RX_Valid, 1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        outs_zero("mid_rst");
        repeat (2) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(2 * CPB);
        send(8'h99, 0, 0);
        idle(20);
        pulses("mid_rst");
        drain("mid_rst");

        for (int g = 0; g < 6; g++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                d  = 8'($urandom);
                bp = ($urandom_range(0, 3) == 0);
                sl = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    d = 8'h00; bp = 0; sl = 1;
                end
                send(d, bp, sl);
                if (sl) idle(2 * CPB);
                else    idle($urandom_range(0, 3));
            end
            idle(20);
            pulses("rnd");
            drain("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
